// File: rtl/state_tx_frame_if.sv
// Byte-serial UDP TX stream: one frame byte per valid cycle, txe marks the last byte.
interface state_tx_frame_if;
    logic [7:0] udp_txd;
    logic       udp_txdv;
    logic       udp_txe;

    modport master (output udp_txd, output udp_txdv, output udp_txe);
    modport slave  (input  udp_txd, input  udp_txdv, input  udp_txe);
endinterface

// File: rtl/state_tx_frame.sv
// Telemetry frame serializer: snapshots header + payload on a periodic or host trigger
// and streams it byte-serially; also keeps a microsecond clock, sequence and drop counters.
module state_tx_frame #(
    parameter int PAYLOAD_BYTES = 96,
    parameter int CLK_MHZ       = 100
) (
    input  logic                       c,
    input  logic                       rst,
    input  logic [15:0]                period_adc,
    input  logic                       sample_dv,
    input  logic                       tx_req,
    input  logic [7:0]                 submsg_id,
    input  logic [7:0]                 payload_len,
    input  logic [PAYLOAD_BYTES*8-1:0] payload,
    state_tx_frame_if.master           tx,
    output logic [63:0]                t_us,
    output logic [15:0]                seq,
    output logic [15:0]                drop_cnt
);
    localparam int         FW      = (11 + PAYLOAD_BYTES) * 8;
    localparam logic [7:0] DIV_MAX = 8'(CLK_MHZ - 1);
    localparam logic [7:0] PB8     = 8'(PAYLOAD_BYTES);

    typedef enum logic {IDLE, TX} state_e;

    state_e          state_q, state_d;
    logic [15:0]     period_q, period_d;
    logic [15:0]     ticks_q, ticks_d;
    logic [7:0]      div_q, div_d;
    logic [63:0]     t_us_q, t_us_d;
    logic [15:0]     seq_q, seq_d;
    logic [15:0]     drop_q, drop_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      len_q, len_d;
    logic [FW-1:0]   frame_q, frame_d;

    logic            period_match, trigger, last_byte, div_wrap;
    logic [7:0]      clamped_len;

    always_ff @(posedge c) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            ticks_q  <= '0;
            div_q    <= '0;
            t_us_q   <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            ticks_q  <= ticks_d;
            div_q    <= div_d;
            t_us_q   <= t_us_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            frame_q  <= frame_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = TX;
            TX:      if (last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and frame datapath
    always_comb begin
        period_match = sample_dv && (ticks_q >= period_q) && (period_q != 16'hffff);
        trigger      = period_match || tx_req;
        last_byte    = (state_q == TX) && (cnt_q == len_q - 8'd1);
        div_wrap     = (div_q == DIV_MAX);
        clamped_len  = (payload_len > PB8) ? PB8 : payload_len;

        period_d = period_adc;
        ticks_d  = period_match ? 16'd0 : (sample_dv ? ticks_q + 16'd1 : ticks_q);
        div_d    = div_wrap ? 8'd0 : div_q + 8'd1;
        t_us_d   = t_us_q + {63'd0, div_wrap};
        seq_d    = seq_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        frame_d  = frame_q;

        if (state_q == IDLE) begin
            if (trigger) begin
                // Byte 0 sits in the low byte; the frame drains by shifting right.
                frame_d = {payload, seq_q, t_us_q, submsg_id};
                len_d   = 8'd11 + clamped_len;
                cnt_d   = 8'd0;
            end
        end else begin
            frame_d = frame_q >> 8;
            cnt_d   = cnt_q + 8'd1;
            if (trigger && drop_q != 16'hffff) drop_d = drop_q + 16'd1;
            if (last_byte) seq_d = seq_q + 16'd1;
        end
    end

    // Outputs
    always_comb begin
        tx.udp_txdv = (state_q == TX);
        tx.udp_txd  = (state_q == TX) ? frame_q[7:0] : 8'd0;
        tx.udp_txe  = last_byte;
        t_us        = t_us_q;
        seq         = seq_q;
        drop_cnt    = drop_q;
    end
endmodule

// File: tb/tb_state_tx_frame.sv
// Randomized scoreboard bench for state_tx_frame against a cycle-count reference model.
module tb_state_tx_frame;
    localparam int PB = 96;
    localparam int CM = 100;

    logic            c = 1'b0;
    logic            rst = 1'b1;
    logic [15:0]     period_adc = 16'hffff;
    logic            sample_dv = 1'b0;
    logic            tx_req = 1'b0;
    logic [7:0]      submsg_id = 8'd0;
    logic [7:0]      payload_len = 8'd0;
    logic [PB*8-1:0] payload = '0;
    logic [63:0]     t_us;
    logic [15:0]     seq, drop_cnt;

    state_tx_frame_if txif ();

    state_tx_frame #(.PAYLOAD_BYTES(PB), .CLK_MHZ(CM)) dut (
        .c(c), .rst(rst), .period_adc(period_adc), .sample_dv(sample_dv),
        .tx_req(tx_req), .submsg_id(submsg_id), .payload_len(payload_len),
        .payload(payload), .tx(txif.master), .t_us(t_us), .seq(seq), .drop_cnt(drop_cnt)
    );

    always #5 c = ~c;

    typedef struct { logic [7:0] d; logic last; } exp_t;
    exp_t expq[$];

    int          n_tests = 0, n_fail = 0;
    bit          mon_en = 0;
    int          frames_done = 0, cur_len = 0, last_len = 0;

    longint      m_n;
    int          m_ticks, m_rem;
    logic [15:0] m_period, m_seq, m_drop;

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: tracks time as elapsed cycles and a frame as a list of bytes.
    initial begin : model
        logic [63:0] tus;
        logic        pm, trig;
        int          L;
        exp_t        e;
        forever begin
            @(posedge c);
            if (rst) begin
                m_n = 0; m_ticks = 0; m_rem = 0;
                m_period = 16'd0; m_seq = 16'd0; m_drop = 16'd0;
                expq.delete();
            end else begin
                tus  = 64'(m_n / CM);
                pm   = sample_dv && (m_ticks >= int'(m_period)) && (m_period != 16'hffff);
                if (pm) m_ticks = 0;
                else if (sample_dv) m_ticks = (m_ticks + 1) % 65536;
                trig = pm || tx_req;
                if (m_rem > 0) begin
                    if (trig && m_drop != 16'hffff) m_drop = m_drop + 16'd1;
                    m_rem--;
                    if (m_rem == 0) m_seq = m_seq + 16'd1;
                end else if (trig) begin
                    L = 11 + ((int'(payload_len) > PB) ? PB : int'(payload_len));
                    for (int k = 0; k < L; k++) begin
                        if (k == 0)       e.d = submsg_id;
                        else if (k <= 8)  e.d = tus[8*(k-1) +: 8];
                        else if (k <= 10) e.d = m_seq[8*(k-9) +: 8];
                        else              e.d = payload[8*(k-11) +: 8];
                        e.last = (k == L - 1);
                        expq.push_back(e);
                    end
                    m_rem = L;
                end
                m_period = period_adc;
                m_n++;
            end
        end
    end

    // Monitor: pops expected bytes whenever the DUT presents one.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge c);
            if (mon_en) begin
                if (rst) cur_len = 0;
                if (txif.udp_txdv) begin
                    cur_len++;
                    if (expq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", txif.udp_txd);
                    end else begin
                        e = expq.pop_front();
                        chk("txd", txif.udp_txd, e.d);
                        chk("txe", txif.udp_txe, e.last);
                    end
                    if (txif.udp_txe) begin
                        frames_done++; last_len = cur_len; cur_len = 0;
                    end
                end else begin
                    chk("idle_txd", txif.udp_txd, 0);
                    chk("idle_txe", txif.udp_txe, 0);
                end
                chk("seq", seq, m_seq);
                chk("drop_cnt", drop_cnt, m_drop);
                chk("t_us", t_us, 64'(m_n / CM));
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge c);
        #1;
    endtask

    task automatic pulse_req();
        tx_req = 1'b1;
        cyc(1);
        tx_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && txif.udp_txdv; i++) cyc(1);
        chk("wait_idle_timeout", txif.udp_txdv, 0);
    endtask

    initial begin : stim
        int f0;
        logic [15:0] d0;
        cyc(1);
        mon_en = 1;
        chk("rst_txdv", txif.udp_txdv, 0);
        chk("rst_seq", seq, 0);
        chk("rst_t_us", t_us, 0);
        cyc(1);
        rst = 1'b0;

        // Microsecond timer boundary around cycle 500
        cyc(499);
        chk("t_us_at_499", t_us, 4);
        cyc(1);
        chk("t_us_at_500", t_us, 5);

        // Periodic trigger every 4th sample
        period_adc = 16'd3; submsg_id = 8'h42; payload_len = 8'd4;
        payload[31:0] = 32'h44332211;
        cyc(2);
        f0 = frames_done;
        for (int s = 0; s < 40; s++) begin
            sample_dv = 1'b1; cyc(1); sample_dv = 1'b0; cyc(9);
        end
        cyc(20);
        chk("periodic_frames", frames_done - f0, 10);
        chk("periodic_len", last_len, 15);

        // Disabled period, then one host request
        period_adc = 16'hffff; cyc(1);
        f0 = frames_done;
        sample_dv = 1'b1; cyc(100); sample_dv = 1'b0;
        chk("disable_no_frames", frames_done - f0, 0);
        pulse_req();
        chk("txreq_latency", txif.udp_txdv, 1);
        cyc(20);
        chk("txreq_one_frame", frames_done - f0, 1);

        // Overrun: late requests at T+5 and T+107 dropped, T+108 accepted
        payload_len = 8'd96;
        d0 = drop_cnt;
        f0 = frames_done;
        pulse_req();
        cyc(4); pulse_req();
        cyc(101); pulse_req();
        pulse_req();
        chk("overrun_restart", txif.udp_txdv, 1);
        chk("overrun_drops", drop_cnt - d0, 2);
        chk("overrun_len", last_len, 107);
        wait_idle();
        chk("overrun_frames", frames_done - f0, 2);

        // Length boundaries
        cyc(2); payload_len = 8'd0; pulse_req(); wait_idle(); cyc(1);
        chk("len0_frame", last_len, 11);
        payload_len = 8'd200; pulse_req(); wait_idle(); cyc(1);
        chk("len200_clamped", last_len, 107);

        // Randomized traffic with payload/ID churn during frames
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) period_adc = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom_range(0, 5));
            sample_dv   = ($urandom_range(0, 3) == 0);
            tx_req      = ($urandom_range(0, 39) == 0);
            submsg_id   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) payload_len = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                for (int b = 0; b < PB; b++) payload[8*b +: 8] = 8'($urandom);
            cyc(1);
        end
        sample_dv = 1'b0; tx_req = 1'b0; period_adc = 16'hffff;
        wait_idle();
        cyc(2);

        // Reset while byte 20 of a 107-byte frame is on the bus
        payload_len = 8'd96;
        f0 = frames_done;
        pulse_req();
        cyc(20);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("midrst_txdv", txif.udp_txdv, 0);
        chk("midrst_txe", txif.udp_txe, 0);
        chk("midrst_seq", seq, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_t_us", t_us, 0);
        chk("midrst_no_eof", frames_done - f0, 0);
        cyc(3);
        pulse_req(); wait_idle(); cyc(1);
        chk("post_rst_frame", frames_done - f0, 1);
        chk("post_rst_seq", seq, 1);

        cyc(5);
        chk("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/state_tx_frame.md
Name: state_tx_frame

Overview:
Parametrised telemetry frame serializer for the motor controller UDP path. It replaces the fixed-layout state transmitter with a generic block that takes a flattened payload bus of PAYLOAD_BYTES bytes and a runtime length. On a periodic ADC-tick trigger or a host one-shot request it snapshots a header and the payload, then streams the frame byte-serially into the UDP TX path. It also provides a free-running microsecond clock, a frame sequence number and an overrun drop counter.

Parameters:
PAYLOAD_BYTES, 96, maximum payload size in bytes (1..244).
CLK_MHZ, 100, clock frequency in MHz, used as the microsecond divider ratio (2..255).

Ports:
c  in  1  clock
rst  in  1  synchronous active-high reset
period_adc  in  16  trigger period in sample_dv ticks; 16'hffff disables periodic trigger
sample_dv  in  1  one-cycle ADC sample strobe
tx_req  in  1  one-cycle host request for an immediate frame
submsg_id  in  8  frame ID byte, sampled at trigger
payload_len  in  8  payload byte count, sampled at trigger
payload  in  PAYLOAD_BYTES*8  payload; byte i is payload[8i+7:8i]
udp_txd  out  8  frame byte
udp_txdv  out  1  byte valid
udp_txe  out  1  end-of-frame, high with the last byte
t_us  out  64  microseconds since reset
seq  out  16  sequence number of the next frame
drop_cnt  out  16  saturating count of triggers lost while busy

Behaviour:
- Reset: all outputs 0; state IDLE; tick counter 0; divider 0.
- period_adc is registered once (period_i) before use, so a change takes effect one cycle later.
- Tick counter: period_match = sample_dv & (ticks >= period_i) & (period_i != 16'hffff). On period_match, ticks <= 0. Otherwise, on sample_dv, ticks <= ticks+1, wrapping at 16 bits. The counter runs in every state.
- Microsecond timer: the divider counts 0..CLK_MHZ-1 and wraps. t_us increments on the cycle the divider equals CLK_MHZ-1.
- trigger = period_match | tx_req. If both are high in the same cycle, one frame is sent.
- States: IDLE and TX.
  - IDLE -> TX on trigger at cycle T. At T the block captures submsg_id, t_us (value before any increment at T), seq, payload, and L = 11 + min(payload_len, PAYLOAD_BYTES) into a shift register.
  - TX -> IDLE after the last byte.
- Frame byte order:
  - byte 0: submsg_id
  - bytes 1..8: t_us, LSB first
  - bytes 9..10: seq, LSB first
  - bytes 11..L-1: payload bytes 0..len-1
- Output timing for a trigger at cycle T:
  - udp_txdv = 1 on cycles T+1..T+L; frame byte k is on udp_txd at cycle T+1+k.
  - udp_txe = 1 only at T+L.
  - At T+L+1: udp_txdv = 0, udp_txd = 0, state IDLE.
  - While idle, udp_txd = 0.
- seq increments by 1 at T+L and wraps at 16'hffff -> 0. The incremented value is visible from T+L+1.
- Back-to-back: a trigger at T+L+1 is accepted, so the minimum frame-to-frame gap is 1 idle cycle.
- Overrun: a trigger on any cycle in T+1..T+L is not queued. drop_cnt increments, saturating at 16'hffff. The tick counter still resets on period_match.
- payload_len = 0 gives an 11-byte header-only frame. payload_len > PAYLOAD_BYTES is clamped.
- Changes to payload or submsg_id during TX do not affect the frame in flight.
- rst mid-frame: the next cycle has udp_txdv = 0 and udp_txe = 0, with no partial end-of-frame, and all counters are cleared.
- Arithmetic widths: L needs 8 bits (max 255). The byte counter is 8 bits.

Test Plan:
- Periodic trigger: period_adc=3, sample_dv every 10 cycles, payload_len=4, payload bytes 0x11,0x22,0x33,0x44, submsg_id=0x42 -> a frame on every 4th sample_dv, 15 bytes each: 0x42, t_us LSB-first, seq 0 then 1, then 11 22 33 44. udp_txe only on byte 14.
- Disable: period_adc=16'hffff with continuous sample_dv -> no frames. A single tx_req -> exactly one frame, starting 1 cycle after the request.
- Overrun: payload_len=96, tx_req at T, then tx_req at T+5 and T+107 -> one frame of 107 bytes. drop_cnt=2 after both late requests; the request at T+107 is also dropped. A tx_req at T+108 starts a new frame at T+109.
- Boundaries: payload_len=0 -> 11-byte frame. payload_len=200 with PAYLOAD_BYTES=96 -> 107-byte frame. seq preset to 0xffff through 65535 frames -> the next frame carries 0xffff and seq then reads 0.
- Timer: CLK_MHZ=100 -> t_us=5 at cycle 500 after reset release. The frame header t_us equals the value at the trigger cycle.
- Reset mid-frame: assert rst at byte 20 of a 107-byte frame -> udp_txdv=0, udp_txe never pulses, seq=0, drop_cnt=0, t_us=0 on the next cycle. After release, tx_req produces a normal frame with seq 0.
